// File: rtl/ysyx_23060203_scoreboard.sv
// Register-hazard scoreboard between decode and the back-end: per-GPR pending-writer counts,
// issue/stall/bypass decision. Optional stall counter enabled by SCOREBOARD_PERF_EN.
module ysyx_23060203_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             clear,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic             dec_use_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs2,
    input  logic [4:0]       dec_rd,
    output logic             issue_ready,
    input  logic             issue_fire,
    input  logic             exu_fwd_valid,
    input  logic [4:0]       exu_fwd_rd,
    output logic             fwd_rs1,
    output logic             fwd_rs2,
    input  logic             wb_commit,
    input  logic [4:0]       wb_rd,
    output logic [CNT_W:0]   inflight,
    output logic             err,
    output logic [31:0]      perf_stall_cycles
);

    localparam logic [CNT_W:0]   MAX_CNT = (CNT_W+1)'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] pend [32];
    logic [CNT_W:0]   inflight_q;
    logic             err_q;

    logic [CNT_W-1:0] pend_rs1, pend_rs2, pend_wb;
    logic             byp1, byp2, wbp1, wbp2, stall1, stall2, full_block;
    logic             inc_req, com_req, com_ok, ovf, inc_ok, err_set;

    always_comb begin
        pend_rs1 = pend[dec_rs1];
        pend_rs2 = pend[dec_rs2];
        pend_wb  = pend[wb_rd];

        // A single pending writer may be satisfied by the EXU bypass or the write-through commit
        byp1 = dec_use_rs1 && (dec_rs1 != '0) && (pend_rs1 == ONE)
            && exu_fwd_valid && (exu_fwd_rd == dec_rs1);
        byp2 = dec_use_rs2 && (dec_rs2 != '0) && (pend_rs2 == ONE)
            && exu_fwd_valid && (exu_fwd_rd == dec_rs2);
        wbp1 = (pend_rs1 == ONE) && wb_commit && (wb_rd == dec_rs1);
        wbp2 = (pend_rs2 == ONE) && wb_commit && (wb_rd == dec_rs2);

        stall1 = dec_use_rs1 && (dec_rs1 != '0) && (pend_rs1 != '0) && !byp1 && !wbp1;
        stall2 = dec_use_rs2 && (dec_rs2 != '0) && (pend_rs2 != '0) && !byp2 && !wbp2;

        full_block  = (dec_rd != '0) && (inflight_q == MAX_CNT) && !wb_commit;
        issue_ready = !flush && !stall1 && !stall2 && !full_block;
        fwd_rs1     = byp1;
        fwd_rs2     = byp2;

        inc_req = issue_fire && issue_ready && (dec_rd != '0);
        com_req = wb_commit && (wb_rd != '0);
        com_ok  = com_req && (pend_wb != '0);
        // Guards the count even when issue_ready was granted on a commit that turns out illegal
        ovf     = inc_req && (inflight_q == MAX_CNT) && !com_ok;
        inc_ok  = inc_req && !ovf;
        err_set = (issue_fire && !issue_ready) || (com_req && !com_ok) || ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) pend[i] <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < 32; i++) pend[i] <= '0;
            inflight_q <= '0;
        end else begin
            if (err_set) err_q <= 1'b1;
            for (int unsigned i = 1; i < 32; i++) begin
                if (inc_ok && (dec_rd == 5'(i)) && !(com_ok && (wb_rd == 5'(i))))
                    pend[i] <= pend[i] + ONE;
                else if (com_ok && (wb_rd == 5'(i)) && !(inc_ok && (dec_rd == 5'(i))))
                    pend[i] <= pend[i] - ONE;
            end
            if (inc_ok && !com_ok)
                inflight_q <= inflight_q + 1'b1;
            else if (com_ok && !inc_ok)
                inflight_q <= inflight_q - 1'b1;
        end
    end

    assign inflight = inflight_q;
    assign err      = err_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clock) begin
        if (reset)
            perf_q <= '0;
        else if (dec_valid && !flush && !issue_ready && (perf_q != '1))
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cycles = perf_q;
`else
    logic unused_dec_valid;
    assign unused_dec_valid  = dec_valid;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060203_scoreboard.sv
// Self-checking bench for ysyx_23060203_scoreboard: vector table, directed sequences, random vs model.
module tb_ysyx_23060203_scoreboard;

    localparam int MAX = 4;

    logic        clock = 1'b0;
    logic        reset, flush, clear, dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, exu_fwd_rd, wb_rd;
    logic        dec_use_rs1, dec_use_rs2, issue_fire, exu_fwd_valid, wb_commit;
    logic        issue_ready, fwd_rs1, fwd_rs2, err;
    logic [3:0]  inflight;
    logic [31:0] perf_stall_cycles;

    bit clk_run = 1'b1;
    always begin
        #5;
        if (clk_run) clock = ~clock;
    end

    ysyx_23060203_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .flush(flush), .clear(clear), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_use_rs1(dec_use_rs1), .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .issue_ready(issue_ready), .issue_fire(issue_fire),
        .exu_fwd_valid(exu_fwd_valid), .exu_fwd_rd(exu_fwd_rd), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .wb_commit(wb_commit), .wb_rd(wb_rd), .inflight(inflight), .err(err),
        .perf_stall_cycles(perf_stall_cycles)
    );

    // Reference model: plain integer bookkeeping of outstanding writers
    int      pend_m [32];
    int      infl_m;
    bit      err_m;
    longint  perf_m;
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic bit m_stall(int s, bit u);
        if (!u || s == 0 || pend_m[s] == 0) return 1'b0;
        if (pend_m[s] == 1 && exu_fwd_valid && int'(exu_fwd_rd) == s) return 1'b0;
        if (pend_m[s] == 1 && wb_commit && int'(wb_rd) == s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_fwd(int s, bit u);
        return u && s != 0 && pend_m[s] == 1 && exu_fwd_valid && int'(exu_fwd_rd) == s;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (m_stall(int'(dec_rs1), dec_use_rs1) || m_stall(int'(dec_rs2), dec_use_rs2)) return 1'b0;
        if (dec_rd != 0 && infl_m == MAX && !wb_commit) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update();
        bit rdy;
        if (reset) begin
            foreach (pend_m[i]) pend_m[i] = 0;
            infl_m = 0;
            err_m  = 1'b0;
            perf_m = 0;
        end else begin
            rdy = m_ready();
`ifdef SCOREBOARD_PERF_EN
            if (dec_valid && !flush && !rdy && perf_m != 64'hFFFF_FFFF) perf_m++;
`endif
            if (clear) begin
                foreach (pend_m[i]) pend_m[i] = 0;
                infl_m = 0;
            end else begin
                if (issue_fire && !rdy) err_m = 1'b1;
                if (wb_commit && wb_rd != 0) begin
                    if (pend_m[wb_rd] == 0) err_m = 1'b1;
                    else begin pend_m[wb_rd]--; infl_m--; end
                end
                if (issue_fire && rdy && dec_rd != 0) begin
                    if (infl_m == MAX) err_m = 1'b1;
                    else begin pend_m[dec_rd]++; infl_m++; end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, 64'(issue_ready), 64'(m_ready()));
        chk({tag, ".fwd1"}, 64'(fwd_rs1), 64'(m_fwd(int'(dec_rs1), dec_use_rs1)));
        chk({tag, ".fwd2"}, 64'(fwd_rs2), 64'(m_fwd(int'(dec_rs2), dec_use_rs2)));
        chk({tag, ".inflight"}, 64'(inflight), 64'(infl_m));
        chk({tag, ".err"}, 64'(err), 64'(err_m));
        chk({tag, ".perf"}, 64'(perf_stall_cycles), 64'(perf_m));
    endtask

    task automatic idle();
        reset = 0; flush = 0; clear = 0; dec_valid = 0;
        dec_rs1 = 0; dec_use_rs1 = 0; dec_rs2 = 0; dec_use_rs2 = 0; dec_rd = 0;
        issue_fire = 0; exu_fwd_valid = 0; exu_fwd_rd = 0; wb_commit = 0; wb_rd = 0;
    endtask

    task automatic tick();
        m_update();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic fire_rd(input int rd);
        idle();
        dec_valid = 1; dec_rd = 5'(rd); issue_fire = 1;
        tick();
        idle();
    endtask

    typedef struct {
        bit fl; int rs1; bit u1; int rs2; bit u2; int rd;
        bit fv; int frd; bit wc; int wrd;
        bit er; bit ef1; bit ef2;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // State for the table: pend[5]=1, pend[7]=2, pend[8]=1, inflight=MAX
        tbl[0]  = '{0, 5,1, 0,0, 0, 0,0, 0,0, 0,0,0};
        tbl[1]  = '{0, 5,1, 0,0, 0, 1,5, 0,0, 1,1,0};
        tbl[2]  = '{0, 5,1, 0,0, 0, 0,0, 1,5, 1,0,0};
        tbl[3]  = '{0, 0,0, 7,1, 0, 1,7, 0,0, 0,0,0};
        tbl[4]  = '{0, 8,0, 0,0, 0, 0,0, 0,0, 1,0,0};
        tbl[5]  = '{0, 0,1, 0,1, 0, 0,0, 0,0, 1,0,0};
        tbl[6]  = '{0, 0,0, 0,0, 6, 0,0, 0,0, 0,0,0};
        tbl[7]  = '{0, 0,0, 0,0, 6, 0,0, 1,1, 1,0,0};
        tbl[8]  = '{1, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0};
        tbl[9]  = '{0, 8,1, 5,1, 3, 1,8, 1,5, 1,1,0};
        tbl[10] = '{0, 5,1, 0,0, 0, 1,6, 0,0, 0,0,0};
        tbl[11] = '{0, 5,1, 5,1, 0, 1,5, 0,0, 1,1,1};
        tbl[12] = '{1, 5,1, 0,0, 0, 1,5, 0,0, 0,1,0};

        // Plan 1: reset state
        do_reset();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1;
        #2;
        chk("rst.ready", 64'(issue_ready), 1);
        chk("rst.fwd1", 64'(fwd_rs1), 0);
        chk("rst.fwd2", 64'(fwd_rs2), 0);
        chk("rst.inflight", 64'(inflight), 0);
        chk("rst.err", 64'(err), 0);
        chk("rst.perf", 64'(perf_stall_cycles), 0);

        // Plan 2: load hazard resolved by same-cycle write-through commit
        fire_rd(5);
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1;
        #1;
        chk("ld.stall", 64'(issue_ready), 0);
        wb_commit = 1; wb_rd = 5;
        #1;
        chk("ld.wbpass", 64'(issue_ready), 1);
        tick();
        idle();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1;
        #1;
        chk("ld.inflight0", 64'(inflight), 0);
        chk("ld.pend0", 64'(issue_ready), 1);

        // Plan 3: EXU bypass with one writer, stall with two
        fire_rd(7);
        dec_valid = 1; dec_rs2 = 7; dec_use_rs2 = 1; exu_fwd_valid = 1; exu_fwd_rd = 7;
        #1;
        chk("byp.ready", 64'(issue_ready), 1);
        chk("byp.fwd2", 64'(fwd_rs2), 1);
        issue_fire = 1;
        tick();
        fire_rd(7);
        dec_valid = 1; dec_rs2 = 7; dec_use_rs2 = 1; exu_fwd_valid = 1; exu_fwd_rd = 7;
        #1;
        chk("byp2.inflight", 64'(inflight), 2);
        chk("byp2.ready", 64'(issue_ready), 0);
        chk("byp2.fwd2", 64'(fwd_rs2), 0);

        // Combinational vector table from a full scoreboard, clock held
        do_reset();
        fire_rd(5); fire_rd(7); fire_rd(7); fire_rd(8);
        clk_run = 0;
        #6;
        chk("tbl.inflight", 64'(inflight), 4);
        for (int i = 0; i < 13; i++) begin
            idle();
            flush = tbl[i].fl; dec_valid = 1;
            dec_rs1 = 5'(tbl[i].rs1); dec_use_rs1 = tbl[i].u1;
            dec_rs2 = 5'(tbl[i].rs2); dec_use_rs2 = tbl[i].u2;
            dec_rd = 5'(tbl[i].rd);
            exu_fwd_valid = tbl[i].fv; exu_fwd_rd = 5'(tbl[i].frd);
            wb_commit = tbl[i].wc; wb_rd = 5'(tbl[i].wrd);
            #1;
            chk($sformatf("tbl%0d.ready", i), 64'(issue_ready), 64'(tbl[i].er));
            chk($sformatf("tbl%0d.fwd1", i), 64'(fwd_rs1), 64'(tbl[i].ef1));
            chk($sformatf("tbl%0d.fwd2", i), 64'(fwd_rs2), 64'(tbl[i].ef2));
        end
        idle();
        clk_run = 1;

        // Plan 4: full scoreboard, commit frees a slot in the same cycle
        do_reset();
        for (int r = 1; r <= 4; r++) fire_rd(r);
        chk("full.inflight4", 64'(inflight), 4);
        dec_valid = 1; dec_rd = 6;
        #1;
        chk("full.block", 64'(issue_ready), 0);
        wb_commit = 1; wb_rd = 1;
        #1;
        chk("full.free", 64'(issue_ready), 1);
        issue_fire = 1;
        tick();
        idle();
        chk("full.after", 64'(inflight), 4);
        chk("full.noerr", 64'(err), 0);

        // Plan 5: same-register issue+commit, illegal commit, clear keeps err
        do_reset();
        fire_rd(3);
        dec_valid = 1; dec_rd = 3; issue_fire = 1; wb_commit = 1; wb_rd = 3;
        tick();
        idle();
        dec_valid = 1; dec_rs1 = 3; dec_use_rs1 = 1;
        #1;
        chk("same.inflight", 64'(inflight), 1);
        chk("same.busy", 64'(issue_ready), 0);
        wb_commit = 1; wb_rd = 3;
        #1;
        chk("same.pend1", 64'(issue_ready), 1);
        idle();
        wb_commit = 1; wb_rd = 9;
        tick();
        idle();
        chk("err.set", 64'(err), 1);
        tick();
        chk("err.sticky", 64'(err), 1);
        chk("err.nodec", 64'(inflight), 1);
        clear = 1;
        tick();
        idle();
        chk("clr.inflight", 64'(inflight), 0);
        chk("clr.errkept", 64'(err), 1);

        // Plan 6: stall counter
        do_reset();
        fire_rd(4);
        dec_valid = 1; dec_rs1 = 4; dec_use_rs1 = 1;
        for (int i = 0; i < 10; i++) tick();
        flush = 1;
        for (int i = 0; i < 3; i++) tick();
`ifdef SCOREBOARD_PERF_EN
        chk("perf.count", 64'(perf_stall_cycles), 10);
`else
        chk("perf.count", 64'(perf_stall_cycles), 0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int start;
            idle();
            reset = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_rs1 = 5'($urandom_range(0, 7)); dec_use_rs1 = 1'($urandom_range(0, 1));
            dec_rs2 = 5'($urandom_range(0, 7)); dec_use_rs2 = 1'($urandom_range(0, 1));
            dec_rd = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            exu_fwd_valid = 1'($urandom_range(0, 1));
            exu_fwd_rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(1, 31);
                for (int k = 0; k < 31; k++) begin
                    int r;
                    r = ((start - 1 + k) % 31) + 1;
                    if (!wb_commit && pend_m[r] > 0) begin
                        wb_commit = 1; wb_rd = 5'(r);
                    end
                end
            end
            if (!wb_commit && $urandom_range(0, 299) == 0) begin
                wb_commit = 1; wb_rd = 5'($urandom_range(0, 31));
            end
            issue_fire = dec_valid && m_ready() && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) issue_fire = 1;
            #2;
            check_model("rnd");
            tick();
        end
        idle();
        #2;
        check_model("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_scoreboard.md
Name: ysyx_23060203_scoreboard

Overview:
- Register-hazard scheduler between the decode stage and the back-end (EXU/LSU/WBU).
- Tracks the number of in-flight GPR writers per architectural register.
- Decides, per decoded instruction, whether it may issue this cycle, must stall, or may take the EXU bypass.
- Generalises the single-stage EXU RAW check to multi-cycle loads and a deeper back-end.

Parameters:
MAX_INFLIGHT, 4, maximum number of issued-but-uncommitted GPR-writing instructions (1..15)
CNT_W, 3, per-register pending counter width; must satisfy 2^CNT_W > MAX_INFLIGHT

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  front-end flush; suppresses issue this cycle
clear  in  1  drop all tracking state (back-end empty after trap/fence.i)
dec_valid  in  1  decode stage holds an instruction
dec_rs1  in  5  source 1 index
dec_use_rs1  in  1  instruction reads rs1
dec_rs2  in  5  source 2 index
dec_use_rs2  in  1  instruction reads rs2
dec_rd  in  5  destination index (0 = no write)
issue_ready  out  1  instruction may issue this cycle
issue_fire  in  1  decode-to-EXU handshake completed (out_valid & out_ready)
exu_fwd_valid  in  1  EXU holds a finished, non-load result
exu_fwd_rd  in  5  destination of that result
fwd_rs1  out  1  select EXU bypass for src1
fwd_rs2  out  1  select EXU bypass for src2
wb_commit  in  1  WBU writes a GPR this cycle
wb_rd  in  5  register being written
inflight  out  CNT_W+1  total tracked writers
err  out  1  sticky protocol error
perf_stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset values:
  - pend[1..31] = 0, inflight = 0, err = 0.
  - Therefore issue_ready = 1, fwd_rs1 = fwd_rs2 = 0, perf_stall_cycles = 0.
- pend[0] is hardwired to 0. rd = 0 is never counted. rs = 0 never stalls and never forwards.
- Per-source hazard evaluation (combinational from registers and inputs, no added latency), for source s with use_s = 1 and s != 0:
  - busy_s = pend[s] != 0.
  - byp_s = (pend[s] == 1) & exu_fwd_valid & (exu_fwd_rd == s).
  - wbp_s = (pend[s] == 1) & wb_commit & (wb_rd == s). The regfile is write-through, so the committing value is visible this cycle.
  - stall_s = busy_s & ~byp_s & ~wbp_s.
  - fwd_rsX = use_X & byp_X (meaningful only when issue_ready = 1).
- issue_ready:
  - issue_ready = ~flush & ~stall_1 & ~stall_2 & ~(dec_rd != 0 & inflight == MAX_INFLIGHT & ~wb_commit).
  - A commit in the same cycle frees a slot.
- Issue: on issue_fire with dec_rd != 0, pend[dec_rd] and inflight increment at the next edge.
- Commit: on wb_commit with wb_rd != 0, pend[wb_rd] and inflight decrement.
- Simultaneous issue and commit:
  - Same register: pend unchanged.
  - Different registers: each updated independently.
  - inflight is unchanged.
- Error conditions (err set, sticky until reset; the offending counter is NOT updated):
  - issue_fire while issue_ready = 0.
  - wb_commit to a register with pend = 0.
  - Increment that would exceed MAX_INFLIGHT.
- clear: next edge zeros all pend and inflight. Same-cycle issue_fire/wb_commit are ignored. err is kept.
- flush: only blocks issue. Back-end instructions still commit normally, so counters stay consistent without rollback.
- reset mid-operation: all state returns to reset values regardless of pending events.

Optional Feature:
- Macro: SCOREBOARD_PERF_EN.
- Defined: perf_stall_cycles increments every cycle with dec_valid & ~flush & ~issue_ready. It saturates at 32'hFFFF_FFFF and is cleared by reset only.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic is synthesised.

Test Plan:
1. Reset, then dec_rs1 = 5, use_rs1 = 1 → issue_ready = 1, fwd_rs1 = 0, inflight = 0.
2. Issue rd = 5 (load, exu_fwd_valid = 0); next cycle decode rs1 = 5 → issue_ready = 0. Then wb_commit rd = 5 in that cycle → issue_ready = 1 in the same cycle, pend[5] returns to 0.
3. Issue rd = 7; next cycle exu_fwd_valid = 1, exu_fwd_rd = 7, decode rs2 = 7 → issue_ready = 1, fwd_rs2 = 1. Then issue rd = 7 twice so pend[7] = 2, with the same EXU bypass → issue_ready = 0.
4. MAX_INFLIGHT = 4: issue rd = 1..4 → inflight = 4. Fifth decode with rd = 6 → issue_ready = 0. Same cycle wb_commit rd = 1 → issue_ready = 1; after the edge inflight stays 4.
5. Issue and commit rd = 3 in the same cycle with pend[3] = 1 → pend[3] stays 1. wb_commit rd = 9 with pend[9] = 0 → err = 1 and stays 1. Then clear → inflight = 0, err still 1.
6. With SCOREBOARD_PERF_EN defined: hold a stall for 10 cycles with dec_valid = 1, then flush for 3 cycles → perf_stall_cycles = 10. Without the macro → perf_stall_cycles = 0.
